// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sequencer that owns the regfile write/read ports.
// INIT writes the power-on image Xi = i into X0..X30. XZR (X31) is never written.
// VERIFY reads the registers back two at a time and records the first mismatch.
// Every port output except err/err_idx is decoded from state and cnt only,
// so start/mode never reach an output combinationally.
module regfile_ctrl #(
  parameter int N    = 64,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [4:0]   err_idx,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic [4:0]   ra1,
  output logic [4:0]   ra2,
  input  logic [N-1:0] rd1,
  input  logic [N-1:0] rd2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [4:0] INIT_LAST   = 5'(NREG - 2);
  localparam logic [4:0] VERIFY_LAST = 5'(NREG / 2 - 1);
  localparam logic [4:0] XZR_IDX     = 5'(NREG - 1);

  state_t     state, state_nx;
  logic [4:0] cnt, cnt_nx;
  logic       err_nx;
  logic [4:0] err_idx_nx;
  logic       mism1, mism2;

  // Power-on image value of register idx (XZR always reads zero).
  function automatic logic [N-1:0] image_val(input logic [4:0] idx);
    logic [N-1:0] v;
    if (idx == XZR_IDX) begin
      v = {N{1'b0}};
    end else begin
      v = {{(N-5){1'b0}}, idx};
    end
    return v;
  endfunction

  // State, counter and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      err     <= 1'b0;
      err_idx <= 5'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      err     <= err_nx;
      err_idx <= err_idx_nx;
    end
  end

  // Port outputs decoded from state and cnt.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    we3  = 1'b0;
    wa3  = 5'd0;
    wd3  = {N{1'b0}};
    ra1  = 5'd0;
    ra2  = 5'd0;
    case (state)
      INIT: begin
        busy = 1'b1;
        we3  = 1'b1;
        wa3  = cnt;
        wd3  = {{(N-5){1'b0}}, cnt};
      end
      VERIFY: begin
        busy = 1'b1;
        ra1  = {cnt[3:0], 1'b0};
        ra2  = {cnt[3:0], 1'b1};
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Read-back comparison against the image; only consumed in VERIFY.
  always_comb begin
    mism1 = (rd1 != image_val(ra1));
    mism2 = (rd2 != image_val(ra2));
  end

  // Next-state, counter and first-mismatch capture.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    err_nx     = err;
    err_idx_nx = err_idx;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nx     = 5'd0;
          err_nx     = 1'b0;
          err_idx_nx = 5'd0;
          state_nx   = mode ? VERIFY : INIT;
        end else begin
          state_nx = IDLE;
        end
      end
      INIT: begin
        cnt_nx = cnt + 5'd1;
        if (cnt == INIT_LAST) begin
          state_nx = DONE;
        end else begin
          state_nx = INIT;
        end
      end
      VERIFY: begin
        cnt_nx = cnt + 5'd1;
        // Port 1 holds the even (lower) index, so it wins a same-cycle tie.
        if (!err && (mism1 || mism2)) begin
          err_nx     = 1'b1;
          err_idx_nx = mism1 ? ra1 : ra2;
        end else begin
          err_nx     = err;
        end
        if (cnt == VERIFY_LAST) begin
          state_nx = DONE;
        end else begin
          state_nx = VERIFY;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: randomized self-checking bench for regfile_ctrl.
// The bench owns a behavioural regfile (with a datapath write port muxed by busy)
// and a shadow image of the intended register contents. VERIFY results are
// predicted by scanning the shadow image for the first register that differs.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic        busy, done, err, we3;
  logic [4:0]  err_idx, wa3, ra1, ra2;
  logic [63:0] wd3, rd1, rd2;

  logic        dp_we;
  logic [4:0]  dp_wa;
  logic [63:0] dp_wd;

  logic [63:0] rf [32] = '{default: 64'd0};
  logic [63:0] shadow [32] = '{default: 64'd0};

  int n_vec = 0;
  int n_err = 0;

  regfile_ctrl #(.N(64), .NREG(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx),
    .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2)
  );

  always #5 clk = ~clk;

  // Behavioural regfile: combinational reads with XZR = 0, write port muxed by busy.
  always_comb begin
    rd1 = (ra1 == 5'd31) ? 64'd0 : rf[ra1];
    rd2 = (ra2 == 5'd31) ? 64'd0 : rf[ra2];
  end

  // Regfile write: controller while busy, datapath otherwise.
  always @(posedge clk) begin
    if (busy) begin
      if (we3) rf[wa3] <= wd3;
    end else if (dp_we) begin
      rf[dp_wa] <= dp_wd;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dp_write(input int idx, input logic [63:0] val);
    dp_we = 1'b1;
    dp_wa = 5'(idx);
    dp_wd = val;
    tick();
    dp_we = 1'b0;
    shadow[idx] = val;
  endtask

  task automatic check_rf();
    for (int i = 0; i < 32; i++) check($sformatf("rf_x%0d", i), rf[i], shadow[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_we3"},  64'(we3),  64'd0);
    check({tag, "_wa3"},  64'(wa3),  64'd0);
    check({tag, "_wd3"},  wd3,       64'd0);
    check({tag, "_ra1"},  64'(ra1),  64'd0);
    check({tag, "_ra2"},  64'(ra2),  64'd0);
  endtask

  // INIT: 31 writes, then one done cycle. spur_at injects an ignored start;
  // abort_at pulls reset low in that cycle (before its write lands).
  task automatic run_init(input int spur_at, input int abort_at);
    start = 1'b1;
    mode  = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 31; c++) begin
      if (c == abort_at) begin
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        check("abort_err", 64'(err), 64'd0);
        check("abort_err_idx", 64'(err_idx), 64'd0);
        for (int i = 0; i < c; i++) shadow[i] = 64'(i);
        for (int k = 0; k < 3; k++) begin
          tick();
          check("abort_no_done", 64'(done), 64'd0);
          check("abort_no_busy", 64'(busy), 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_idle_outputs("post_abort");
        return;
      end
      check($sformatf("init_we3_c%0d", c), 64'(we3), 64'd1);
      check($sformatf("init_wa3_c%0d", c), 64'(wa3), 64'(c));
      check($sformatf("init_wd3_c%0d", c), wd3, 64'(c));
      check($sformatf("init_ra_c%0d", c), 64'({ra1, ra2}), 64'd0);
      check($sformatf("init_busy_c%0d", c), 64'(busy), 64'd1);
      check($sformatf("init_done_c%0d", c), 64'(done), 64'd0);
      check($sformatf("init_err_c%0d", c), 64'(err), 64'd0);
      if (c == spur_at) begin
        start = 1'b1;
        mode  = 1'($urandom);
      end
      tick();
      start = 1'b0;
    end
    check("init_done_pulse", 64'(done), 64'd1);
    check("init_done_busy", 64'(busy), 64'd0);
    check("init_done_we3", 64'(we3), 64'd0);
    start = 1'b1;
    mode  = 1'($urandom);
    tick();
    start = 1'b0;
    check("init_done_once", 64'(done), 64'd0);
    check("init_start_in_done_ignored", 64'(busy), 64'd0);
    tick();
    check("init_idle_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 31; i++) shadow[i] = 64'(i);
  endtask

  // VERIFY with the first-mismatch index predicted from the shadow image.
  task automatic run_verify(input int spur_at);
    int first_bad;
    logic exp_err;
    first_bad = -1;
    for (int i = 0; i < 32; i++) begin
      if (first_bad < 0 && shadow[i] != ((i == 31) ? 64'd0 : 64'(i))) first_bad = i;
    end
    start = 1'b1;
    mode  = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      exp_err = (first_bad >= 0) && (first_bad < 2 * c);
      check($sformatf("ver_ra1_c%0d", c), 64'(ra1), 64'(2 * c));
      check($sformatf("ver_ra2_c%0d", c), 64'(ra2), 64'(2 * c + 1));
      check($sformatf("ver_we3_c%0d", c), 64'(we3), 64'd0);
      check($sformatf("ver_busy_c%0d", c), 64'(busy), 64'd1);
      check($sformatf("ver_done_c%0d", c), 64'(done), 64'd0);
      check($sformatf("ver_err_c%0d", c), 64'(err), 64'(exp_err));
      if (exp_err) check($sformatf("ver_err_idx_c%0d", c), 64'(err_idx), 64'(first_bad));
      if (c == spur_at) begin
        start = 1'b1;
        mode  = 1'($urandom);
      end
      tick();
      start = 1'b0;
    end
    exp_err = (first_bad >= 0);
    check("ver_done_pulse", 64'(done), 64'd1);
    check("ver_done_busy", 64'(busy), 64'd0);
    check("ver_err", 64'(err), 64'(exp_err));
    check("ver_err_idx", 64'(err_idx), exp_err ? 64'(first_bad) : 64'd0);
    tick();
    check("ver_done_once", 64'(done), 64'd0);
    check("ver_err_sticky", 64'(err), 64'(exp_err));
    check("ver_idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int nc;
    int idx;
    reset = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    dp_we = 1'b0;
    dp_wa = 5'd0;
    dp_wd = 64'd0;
    #2;
    check_idle_outputs("reset");
    check("reset_err", 64'(err), 64'd0);
    check("reset_err_idx", 64'(err_idx), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_idle_outputs("idle");

    // Basic INIT with an ignored start in cycle 10, then clean VERIFY.
    run_init(10, -1);
    check_rf();
    run_verify(-1);

    // Single corruption, then sticky err across idle cycles.
    dp_write(17, 64'd99);
    run_verify(5);
    repeat (3) tick();
    check("sticky_err", 64'(err), 64'd1);
    check("sticky_err_idx", 64'(err_idx), 64'd17);

    // Lowest index wins; port 1 beats port 2 within a pair.
    run_init(-1, -1);
    dp_write(4, 64'd7);
    dp_write(20, 64'd0);
    run_verify(-1);
    run_init(-1, -1);
    dp_write(9, 64'd0);
    dp_write(8, 64'h8000_0000_0000_0008);
    run_verify(-1);

    // Randomized rounds.
    for (int r = 0; r < 6; r++) begin
      run_init(int'($urandom_range(0, 40)), -1);
      check_rf();
      nc = int'($urandom_range(0, 3));
      for (int k = 0; k < nc; k++) begin
        idx = int'($urandom_range(0, 30));
        dp_write(idx, ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 31))
                                                  : {$urandom, $urandom});
      end
      repeat (int'($urandom_range(0, 3))) tick();
      run_verify(int'($urandom_range(0, 20)));
    end

    // Abort INIT with err set: reset clears err, partial writes remain.
    run_init(-1, -1);
    dp_write(3, 64'd33);
    dp_write(13, 64'd1234);
    dp_write(5, 64'd0);
    run_verify(-1);
    run_init(-1, 13);
    check_rf();
    run_init(-1, -1);
    check_rf();
    run_verify(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Sequencer that owns the write and read ports of the 32-entry regfile (X31 = XZR, reads 0, writes ignored).
- Two operations:
  - INIT: loads the power-on image Xi = i for i = 0..30.
  - VERIFY: reads every register back in pairs through both read ports and flags mismatches against the same image.
- Sits beside the datapath; the datapath regfile port mux selects this block while busy=1.

Parameters:
- N, 64, data width of regfile entries.
- NREG, 32, number of architectural registers; the last index is XZR.

Ports:
- clk    input   1   clock; all state updates on posedge.
- reset  input   1   asynchronous, active-low reset.
- start  input   1   one-cycle request; sampled on posedge only when the FSM is in IDLE.
- mode   input   1   0 = INIT, 1 = VERIFY; sampled together with start.
- busy   output  1   high while the FSM is in INIT or VERIFY.
- done   output  1   one-cycle pulse when an operation finishes.
- err    output  1   sticky mismatch flag from VERIFY; cleared by the next accepted start.
- err_idx  output  5   index of the first mismatching register; valid when err=1.
- we3    output  1   regfile write enable.
- wa3    output  5   regfile write address.
- wd3    output  N   regfile write data.
- ra1    output  5   regfile read address, port 1.
- ra2    output  5   regfile read address, port 2.
- rd1    input   N   regfile read data, port 1 (combinational from ra1).
- rd2    input   N   regfile read data, port 2 (combinational from ra2).

Behaviour:
- State registers: state ∈ {IDLE, INIT, VERIFY, DONE}, cnt[4:0], err, err_idx.
- All outputs except err/err_idx are decoded from state and cnt only. There is no combinational path from start/mode to outputs.
- Reset (reset=0, asynchronous):
  - state = IDLE, cnt = 0, err = 0, err_idx = 0.
  - Hence busy = 0, done = 0, we3 = 0, wa3 = 0, wd3 = 0, ra1 = 0, ra2 = 0.
- IDLE:
  - All outputs 0 (err/err_idx hold).
  - On posedge with start=1: cnt ← 0, err ← 0, err_idx ← 0; go to INIT if mode=0, else VERIFY.
- INIT:
  - we3 = 1, wa3 = cnt, wd3 = zero-extended cnt; ra1 = ra2 = 0.
  - Each posedge: the regfile captures the write, then cnt ← cnt + 1.
  - When cnt = NREG-2 (30), the next state is DONE. XZR is never written.
  - Length: exactly 31 cycles with we3 = 1.
- VERIFY:
  - we3 = 0, ra1 = 2·cnt, ra2 = 2·cnt + 1.
  - expected(i) = i for i < NREG-1; expected(NREG-1) = 0.
  - Compare rd1 and rd2 against expected in the same cycle. At the posedge, if either mismatches and err = 0: err ← 1, err_idx ← the lowest mismatching index (port 1 before port 2).
  - Later mismatches do not change err_idx.
  - When cnt = NREG/2-1 (15), the next state is DONE. Length: 16 cycles.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle, then IDLE.
  - start during DONE is ignored.
- start while busy or in DONE: ignored; no queuing.
- Latency: start accepted at edge T →
  - INIT: done high in cycle [T+31, T+32).
  - VERIFY: done high in cycle [T+16, T+17).
- Reset asserted mid-operation: the operation aborts immediately.
  - Partially written registers keep their values.
  - err is cleared; no done pulse.
- Width rules:
  - wd3 = {(N-5)'b0, cnt}.
  - ra2 computation uses 5-bit arithmetic; the maximum is 31, so there is no wrap.

Test Plan:
- Reset release, then start=1 mode=0 for one cycle → we3=1 for 31 consecutive cycles with wa3/wd3 = 0,1,…,30; then done pulses once; reading X5 returns 5, X31 returns 0.
- INIT, then start mode=1 → 16 cycles with (ra1,ra2) = (0,1)…(30,31); done pulse; err=0.
- INIT, then the bench overwrites X17 = 99 via the datapath port, then VERIFY → err=1, err_idx=17 at done; err stays 1 until the next start.
- INIT, corrupt X4 = 7 and X20 = 0, then VERIFY → err_idx=4, not 20.
- start pulsed again during INIT cycle 10 → ignored; the write sequence continues unchanged, and exactly one done pulse occurs.
- reset=0 during INIT after wa3=12 → all outputs 0 asynchronously, state IDLE, no done; X0–X12 hold written values; a fresh INIT completes normally.
